cmos_window_crop: RTL and testbench
===================================

# cmos_window_crop

Parametrised camera-side window/decimation stage between the CMOS capture block and the SDRAM write FIFO. Crops a runtime-programmable rectangle out of the incoming source frame, optionally decimates it by 2 or 4 in both axes, and tags frame start and line end. Configuration is shadowed at each frame start so a frame is never cut with mixed settings. Also reports the effective output resolution and the SDRAM frame word count.

## Interface
- DATA_W, 16, pixel width
- CNT_W, 11, width of all pixel/line counters and config fields
- SRC_H, 640, source pixels per line
- SRC_V, 480, source lines per frame

- cam_pclk  in  1  pixel clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- cfg_x0, cfg_y0  in  CNT_W each  window top-left corner (source pixels/lines)
- cfg_w, cfg_h  in  CNT_W each  window size in source pixels/lines
- cfg_skip  in  2  decimation: 0 = 1:1, 1 = 2:1, 2 = 4:1, 3 = reserved (error)
- cfg_bypass  in  1  pass full source frame, ignore window and skip
- cam_vsync, cam_href  in  1 each  frame/line syncs from capture
- cam_data  in  DATA_W  pixel
- cam_data_valid  in  1  pixel strobe
- out_valid  out  1  output pixel strobe
- out_data  out  DATA_W  output pixel; 0 when out_valid low
- out_sof  out  1  with first output pixel of a frame
- out_eol  out  1  with last output pixel of a line
- frame_h, frame_v  out  CNT_W each  effective output resolution of current frame
- pix_max  out  2*CNT_W  frame_h * frame_v (SDRAM max write address)
- cfg_err  out  1  shadowed config invalid, full-frame passthrough in force

## Operation
- Sync edges: vsync_d0/href_d0 registered copies; sof_edge = cam_vsync & ~vsync_d0; eol_edge = ~cam_href & href_d0.
- Shadow registers load on sof_edge from cfg_*. Invalid if any: cfg_w == 0, cfg_h == 0, cfg_x0+cfg_w > SRC_H, cfg_y0+cfg_h > SRC_V (sums computed CNT_W+1 wide), cfg_skip == 3, cfg_w or cfg_h not a multiple of 2^cfg_skip. Invalid or cfg_bypass: window = (0,0,SRC_H,SRC_V), skip 0; cfg_err = invalid (bypass alone does not set it).
- frame_h = w >> skip, frame_v = h >> skip, pix_max registered product; all update one cycle after shadow load.
- h_cnt: cleared on sof_edge or eol_edge, else +1 per cam_data_valid. v_cnt: cleared on sof_edge, +1 on eol_edge. Saturate at all-ones.
- Keep pixel when: x0 <= h_cnt < x0+w, y0 <= v_cnt < y0+h, (h_cnt-x0) and (v_cnt-y0) low skip bits zero.
- FSM: WAIT_SOF (after reset; drop everything) -> ACTIVE on sof_edge. ACTIVE -> DONE on eol_edge when v_cnt == y0+h-1 (last window line). DONE -> ACTIVE on sof_edge; drops all pixels. sof_edge in ACTIVE restarts frame (short frame, no error).
- Pixels only emitted in ACTIVE.
- out_sof on first kept pixel after entering ACTIVE (one-shot flag). out_eol on kept pixel with h_cnt == x0+w-2^skip.

## Timing
- Latency: cam_data_valid/cam_data at cycle N -> out_valid/out_data at N+1, all outputs registered.
- Reset values: out_valid 0, out_data 0, out_sof 0, out_eol 0, frame_h SRC_H, frame_v SRC_V, pix_max SRC_H*SRC_V, cfg_err 0, FSM WAIT_SOF.
- sof_edge coincident with cam_data_valid: edge wins, pixel dropped, counters cleared.
- eol_edge coincident with cam_data_valid: pixel evaluated with pre-clear h_cnt, then h_cnt cleared.
- cfg_* changes mid-frame have no effect until next sof_edge.
- Reset mid-frame: outputs 0 next edge; remainder of frame discarded until next sof_edge.

## Structure
- Package cmos_pkg: skip encoding constants, shared default SRC_H/SRC_V, a window-config struct typedef (x0, y0, w, h, skip).
- One sub-module natural: cmos_win_cfg (validation, shadow load, frame_h/frame_v/pix_max); counters, FSM, datapath in top.

## Test plan
- Bypass, 640x480 ramp frame -> 307200 out_valid pulses, data identical delayed 1 cycle, pix_max 307200, one out_sof, 480 out_eol.
- Window x0=80,y0=60,w=480,h=272, skip 0 -> first output = source (80,60), 480 pixels/line, 272 lines, pix_max 130560.
- Same window, skip 1 -> 240x136 output, only even-offset pixels/lines, out_eol at h_cnt 558, pix_max 32640.
- cfg_x0=400,cfg_w=400 -> cfg_err 1, full 640x480 passthrough; fix config mid-frame -> takes effect only next frame.
- Reset asserted mid-line frame 1 -> outputs 0 immediately, no output until next vsync rise; vsync rise coincident with valid pixel -> pixel dropped.

Source files
------------

// File: rtl/cmos_pkg.sv
// Shared types and constants for the camera window/decimation stage.
// Holds the skip encodings, default source geometry, the shadow-window struct and the FSM states.
package cmos_pkg;

  localparam int SRC_H_DEF = 640;
  localparam int SRC_V_DEF = 480;
  // Width of the window struct fields; the CNT_W parameter of the blocks must match it.
  localparam int WIN_W     = 11;

  localparam logic [1:0] SKIP_1_1  = 2'd0;
  localparam logic [1:0] SKIP_2_1  = 2'd1;
  localparam logic [1:0] SKIP_4_1  = 2'd2;
  localparam logic [1:0] SKIP_RSVD = 2'd3;

  typedef struct packed {
    logic [WIN_W-1:0] x0;
    logic [WIN_W-1:0] y0;
    logic [WIN_W-1:0] w;
    logic [WIN_W-1:0] h;
    logic [1:0]       skip;
  } win_cfg_t;

  typedef enum logic [1:0] {
    ST_WAIT_SOF = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_DONE     = 2'd2
  } crop_state_t;

  // Low-bit mask that must be zero for a coordinate offset to survive decimation.
  function automatic logic [1:0] skip_mask(input logic [1:0] skip);
    case (skip)
      SKIP_1_1: return 2'b00;
      SKIP_2_1: return 2'b01;
      default:  return 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/cmos_win_cfg.sv
// Validates the programmed window, shadows it at frame start and derives the output geometry.
// Invalid or bypassed configurations fall back to the full source frame at 1:1.
module cmos_win_cfg
  import cmos_pkg::*;
#(
  parameter int CNT_W = WIN_W,
  parameter int SRC_H = SRC_H_DEF,
  parameter int SRC_V = SRC_V_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [CNT_W-1:0]   cfg_x0_i,
  input  logic [CNT_W-1:0]   cfg_y0_i,
  input  logic [CNT_W-1:0]   cfg_w_i,
  input  logic [CNT_W-1:0]   cfg_h_i,
  input  logic [1:0]         cfg_skip_i,
  input  logic               cfg_bypass_i,
  output win_cfg_t           win_o,
  output logic [CNT_W-1:0]   frame_h_o,
  output logic [CNT_W-1:0]   frame_v_o,
  output logic [2*CNT_W-1:0] pix_max_o,
  output logic               cfg_err_o
);

  localparam logic [CNT_W:0] SRC_H_L = (CNT_W+1)'(SRC_H);
  localparam logic [CNT_W:0] SRC_V_L = (CNT_W+1)'(SRC_V);

  win_cfg_t           full_s;
  win_cfg_t           win_d;
  win_cfg_t           win_q;
  logic [CNT_W:0]     x_sum_s;
  logic [CNT_W:0]     y_sum_s;
  logic               align_s;
  logic               invalid_s;
  logic               err_q;
  logic [CNT_W-1:0]   frame_h_d;
  logic [CNT_W-1:0]   frame_v_d;
  logic [CNT_W-1:0]   frame_h_q;
  logic [CNT_W-1:0]   frame_v_q;
  logic [2*CNT_W-1:0] pix_max_q;

  always_comb begin
    full_s      = '0;
    full_s.w    = CNT_W'(SRC_H);
    full_s.h    = CNT_W'(SRC_V);
    full_s.skip = SKIP_1_1;

    x_sum_s   = {1'b0, cfg_x0_i} + {1'b0, cfg_w_i};
    y_sum_s   = {1'b0, cfg_y0_i} + {1'b0, cfg_h_i};
    align_s   = ((cfg_w_i[1:0] | cfg_h_i[1:0]) & skip_mask(cfg_skip_i)) == 2'b00;
    invalid_s = (cfg_w_i == '0) || (cfg_h_i == '0) || (x_sum_s > SRC_H_L) ||
                (y_sum_s > SRC_V_L) || (cfg_skip_i == SKIP_RSVD) || !align_s;

    if (invalid_s || cfg_bypass_i) begin
      win_d = full_s;
    end else begin
      win_d.x0   = cfg_x0_i;
      win_d.y0   = cfg_y0_i;
      win_d.w    = cfg_w_i;
      win_d.h    = cfg_h_i;
      win_d.skip = cfg_skip_i;
    end

    frame_h_d = win_q.w >> win_q.skip;
    frame_v_d = win_q.h >> win_q.skip;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      win_q <= full_s;
      err_q <= 1'b0;
    end else if (load_i) begin
      win_q <= win_d;
      err_q <= invalid_s;
    end
  end

  // Geometry trails the shadow by one cycle so the multiplier sits behind a register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_h_q <= CNT_W'(SRC_H);
      frame_v_q <= CNT_W'(SRC_V);
      pix_max_q <= (2*CNT_W)'(SRC_H * SRC_V);
    end else begin
      frame_h_q <= frame_h_d;
      frame_v_q <= frame_v_d;
      pix_max_q <= {{CNT_W{1'b0}}, frame_h_d} * {{CNT_W{1'b0}}, frame_v_d};
    end
  end

  assign win_o     = win_q;
  assign frame_h_o = frame_h_q;
  assign frame_v_o = frame_v_q;
  assign pix_max_o = pix_max_q;
  assign cfg_err_o = err_q;

endmodule

// File: rtl/cmos_window_crop.sv
// Camera window crop and 1:1/2:1/4:1 decimation between CMOS capture and the SDRAM write FIFO.
// Counters, frame FSM and the registered output datapath live here; config shadowing is in cmos_win_cfg.
module cmos_window_crop
  import cmos_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = WIN_W,
  parameter int SRC_H  = SRC_H_DEF,
  parameter int SRC_V  = SRC_V_DEF
) (
  input  logic               cam_pclk,
  input  logic               rst,
  input  logic [CNT_W-1:0]   cfg_x0,
  input  logic [CNT_W-1:0]   cfg_y0,
  input  logic [CNT_W-1:0]   cfg_w,
  input  logic [CNT_W-1:0]   cfg_h,
  input  logic [1:0]         cfg_skip,
  input  logic               cfg_bypass,
  input  logic               cam_vsync,
  input  logic               cam_href,
  input  logic [DATA_W-1:0]  cam_data,
  input  logic               cam_data_valid,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_sof,
  output logic               out_eol,
  output logic [CNT_W-1:0]   frame_h,
  output logic [CNT_W-1:0]   frame_v,
  output logic [2*CNT_W-1:0] pix_max,
  output logic               cfg_err
);

  win_cfg_t          win_s;
  crop_state_t       state_q, state_d;
  logic              vsync_d0_q, href_d0_q;
  logic              sof_edge_s, eol_edge_s;
  logic [CNT_W-1:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic              sof_pend_q, sof_pend_d;
  logic [CNT_W:0]    x_end_s, y_end_s, x_last_s, y_last_s;
  logic [1:0]        mask_s, dx_lo_s, dy_lo_s;
  logic              in_x_s, in_y_s, keep_s;
  logic              out_valid_q, out_sof_q, out_eol_q;
  logic [DATA_W-1:0] out_data_q;

  cmos_win_cfg #(.CNT_W(CNT_W), .SRC_H(SRC_H), .SRC_V(SRC_V)) u_cfg (
    .clk_i        (cam_pclk),
    .rst_i        (rst),
    .load_i       (sof_edge_s),
    .cfg_x0_i     (cfg_x0),
    .cfg_y0_i     (cfg_y0),
    .cfg_w_i      (cfg_w),
    .cfg_h_i      (cfg_h),
    .cfg_skip_i   (cfg_skip),
    .cfg_bypass_i (cfg_bypass),
    .win_o        (win_s),
    .frame_h_o    (frame_h),
    .frame_v_o    (frame_v),
    .pix_max_o    (pix_max),
    .cfg_err_o    (cfg_err)
  );

  assign sof_edge_s = cam_vsync & ~vsync_d0_q;
  assign eol_edge_s = ~cam_href & href_d0_q;

  always_comb begin
    h_cnt_d = h_cnt_q;
    if (sof_edge_s || eol_edge_s) begin
      h_cnt_d = '0;
    end else if (cam_data_valid && (h_cnt_q != '1)) begin
      h_cnt_d = h_cnt_q + 1'b1;
    end else begin
      h_cnt_d = h_cnt_q;
    end

    v_cnt_d = v_cnt_q;
    if (sof_edge_s) begin
      v_cnt_d = '0;
    end else if (eol_edge_s && (v_cnt_q != '1)) begin
      v_cnt_d = v_cnt_q + 1'b1;
    end else begin
      v_cnt_d = v_cnt_q;
    end
  end

  always_comb begin
    mask_s   = skip_mask(win_s.skip);
    x_end_s  = {1'b0, win_s.x0} + {1'b0, win_s.w};
    y_end_s  = {1'b0, win_s.y0} + {1'b0, win_s.h};
    x_last_s = x_end_s - {{(CNT_W-1){1'b0}}, mask_s} - {{CNT_W{1'b0}}, 1'b1};
    y_last_s = y_end_s - {{CNT_W{1'b0}}, 1'b1};
    dx_lo_s  = h_cnt_q[1:0] - win_s.x0[1:0];
    dy_lo_s  = v_cnt_q[1:0] - win_s.y0[1:0];
    in_x_s   = (h_cnt_q >= win_s.x0) && ({1'b0, h_cnt_q} < x_end_s);
    in_y_s   = (v_cnt_q >= win_s.y0) && ({1'b0, v_cnt_q} < y_end_s);
    keep_s   = (state_q == ST_ACTIVE) && cam_data_valid && !sof_edge_s && in_x_s && in_y_s &&
               ((dx_lo_s & mask_s) == 2'b00) && ((dy_lo_s & mask_s) == 2'b00);
  end

  always_comb begin
    state_d    = state_q;
    sof_pend_d = sof_pend_q;
    case (state_q)
      ST_WAIT_SOF: begin
        if (sof_edge_s) state_d = ST_ACTIVE;
        else            state_d = ST_WAIT_SOF;
      end
      ST_ACTIVE: begin
        if (sof_edge_s)                                         state_d = ST_ACTIVE;
        else if (eol_edge_s && ({1'b0, v_cnt_q} == y_last_s))   state_d = ST_DONE;
        else                                                    state_d = ST_ACTIVE;
      end
      ST_DONE: begin
        if (sof_edge_s) state_d = ST_ACTIVE;
        else            state_d = ST_DONE;
      end
      default: state_d = ST_WAIT_SOF;
    endcase

    // A short frame restarted by sof_edge re-arms the start-of-frame tag as well.
    if (sof_edge_s)  sof_pend_d = 1'b1;
    else if (keep_s) sof_pend_d = 1'b0;
    else             sof_pend_d = sof_pend_q;
  end

  // vsync_d0 resets high so a vsync already high when reset drops is not mistaken for a frame start.
  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      vsync_d0_q  <= 1'b1;
      href_d0_q   <= 1'b0;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      state_q     <= ST_WAIT_SOF;
      sof_pend_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
    end else begin
      vsync_d0_q  <= cam_vsync;
      href_d0_q   <= cam_href;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      state_q     <= state_d;
      sof_pend_q  <= sof_pend_d;
      out_valid_q <= keep_s;
      out_data_q  <= keep_s ? cam_data : '0;
      out_sof_q   <= keep_s && sof_pend_q;
      out_eol_q   <= keep_s && ({1'b0, h_cnt_q} == x_last_s);
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sof   = out_sof_q;
  assign out_eol   = out_eol_q;

endmodule

// File: tb/tb_cmos_window_crop.sv
// Directed bench for cmos_window_crop on a reduced 64x48 source frame.
// Each cycle's output is sampled 1 ns after the edge, so every captured pixel is the pixel driven that cycle.
module tb_cmos_window_crop;

  localparam int SH = 64;
  localparam int SV = 48;

  typedef struct packed {
    logic [15:0] d;
    logic        s;
    logic        e;
  } cap_t;

  logic        cam_pclk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] cfg_x0 = '0, cfg_y0 = '0, cfg_w = '0, cfg_h = '0;
  logic [1:0]  cfg_skip = '0;
  logic        cfg_bypass = 1'b0;
  logic        cam_vsync = 1'b0, cam_href = 1'b0, cam_data_valid = 1'b0;
  logic [15:0] cam_data = '0;
  logic        out_valid, out_sof, out_eol, cfg_err;
  logic [15:0] out_data;
  logic [10:0] frame_h, frame_v;
  logic [21:0] pix_max;

  int   n_vec = 0;
  int   n_err = 0;
  int   zero_viol = 0;
  cap_t cap_q[$];

  cmos_window_crop #(.DATA_W(16), .CNT_W(11), .SRC_H(SH), .SRC_V(SV)) dut (
    .cam_pclk(cam_pclk), .rst(rst),
    .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .cfg_skip(cfg_skip), .cfg_bypass(cfg_bypass),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .cam_data_valid(cam_data_valid),
    .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof), .out_eol(out_eol),
    .frame_h(frame_h), .frame_v(frame_v), .pix_max(pix_max), .cfg_err(cfg_err)
  );

  always #5 cam_pclk = ~cam_pclk;

  function automatic logic [15:0] pat(input int l, input int p);
    return {l[7:0], p[7:0]};
  endfunction

  task automatic tick(input logic vs, input logic hr, input logic dv, input logic [15:0] d);
    cam_vsync = vs; cam_href = hr; cam_data_valid = dv; cam_data = d;
    @(posedge cam_pclk); #1;
    if (out_valid === 1'b1) cap_q.push_back({out_data, out_sof, out_eol});
    else if (out_data !== 16'h0000) zero_viol++;
  endtask

  task automatic set_cfg(input int x0, input int y0, input int w, input int h, input int s, input bit byp);
    cfg_x0 = 11'(x0); cfg_y0 = 11'(y0); cfg_w = 11'(w); cfg_h = 11'(h);
    cfg_skip = 2'(s); cfg_bypass = byp;
  endtask

  task automatic drive_frame(input int fix_line);
    cap_q.delete();
    zero_viol = 0;
    tick(1'b1, 1'b0, 1'b0, 16'h0000);
    tick(1'b1, 1'b0, 1'b0, 16'h0000);
    tick(1'b0, 1'b0, 1'b0, 16'h0000);
    tick(1'b0, 1'b0, 1'b0, 16'h0000);
    for (int l = 0; l < SV; l++) begin
      if (l == fix_line) set_cfg(8, 6, 48, 28, 0, 1'b0);
      for (int p = 0; p < SH; p++) tick(1'b0, 1'b1, 1'b1, pat(l, p));
      repeat (3) tick(1'b0, 1'b0, 1'b0, 16'h0000);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge cam_pclk);
    #1 rst = 1'b0;
    n_vec++; if ({out_valid, out_sof, out_eol} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {out_valid, out_sof, out_eol}); end
    n_vec++; if (out_data !== 16'h0000) begin n_err++; $display("FAIL reset_data: got %h want 0000", out_data); end
    n_vec++; if (frame_h !== 11'd64 || frame_v !== 11'd48) begin n_err++; $display("FAIL reset_geom: got %0dx%0d want 64x48", frame_h, frame_v); end
    n_vec++; if (pix_max !== 22'd3072) begin n_err++; $display("FAIL reset_pixmax: got %0d want 3072", pix_max); end
    n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", cfg_err); end
    cap_q.delete();
    for (int p = 0; p < 10; p++) tick(1'b0, 1'b1, 1'b1, pat(0, p));
    tick(1'b0, 1'b0, 1'b0, 16'h0000);
    n_vec++; if (cap_q.size() != 0) begin n_err++; $display("FAIL wait_sof_drop: got %0d pixels want 0", cap_q.size()); end
  endtask

  task automatic test_window(input string name, input int x0, input int y0, input int w, input int h,
                             input int s, input bit byp, input int ex0, input int ey0, input int es,
                             input int efh, input int efv, input int epm, input bit eerr);
    int   nchk;
    cap_t e;
    set_cfg(x0, y0, w, h, s, byp);
    drive_frame(-1);
    n_vec++; if (cap_q.size() != epm) begin n_err++; $display("FAIL %s count: got %0d want %0d", name, cap_q.size(), epm); end
    nchk = (cap_q.size() < epm) ? cap_q.size() : epm;
    for (int k = 0; k < nchk; k++) begin
      e.d = pat(ey0 + (k / efh) * es, ex0 + (k % efh) * es);
      e.s = (k == 0);
      e.e = ((k % efh) == efh - 1);
      n_vec++;
      if (cap_q[k] !== e) begin
        n_err++;
        $display("FAIL %s px%0d: got d=%h sof=%b eol=%b want d=%h sof=%b eol=%b",
                 name, k, cap_q[k].d, cap_q[k].s, cap_q[k].e, e.d, e.s, e.e);
      end
    end
    n_vec++; if (frame_h !== 11'(efh) || frame_v !== 11'(efv)) begin n_err++; $display("FAIL %s geom: got %0dx%0d want %0dx%0d", name, frame_h, frame_v, efh, efv); end
    n_vec++; if (pix_max !== 22'(epm)) begin n_err++; $display("FAIL %s pixmax: got %0d want %0d", name, pix_max, epm); end
    n_vec++; if (cfg_err !== eerr) begin n_err++; $display("FAIL %s cfg_err: got %b want %b", name, cfg_err, eerr); end
    n_vec++; if (zero_viol != 0) begin n_err++; $display("FAIL %s idle_data: got %0d nonzero idle cycles want 0", name, zero_viol); end
  endtask

  task automatic test_cfg_checks();
    // x0, y0, w, h, skip, bypass, expected err, frame_h, frame_v, pix_max
    int tbl [10][10] = '{
      '{16,  0, 48, 48, 0, 0, 0, 48, 48, 2304},
      '{16,  0, 49, 48, 0, 0, 1, 64, 48, 3072},
      '{ 0, 20, 64, 28, 0, 0, 0, 64, 28, 1792},
      '{ 0, 21, 64, 28, 0, 0, 1, 64, 48, 3072},
      '{ 0,  0,  0, 10, 0, 0, 1, 64, 48, 3072},
      '{ 0,  0, 64, 48, 3, 0, 1, 64, 48, 3072},
      '{ 0,  0, 46, 48, 2, 0, 1, 64, 48, 3072},
      '{ 0,  0, 46, 48, 1, 0, 0, 23, 24,  552},
      '{ 0,  0, 44, 48, 2, 1, 0, 64, 48, 3072},
      '{40,  0, 40, 48, 0, 1, 1, 64, 48, 3072}
    };
    for (int i = 0; i < 10; i++) begin
      set_cfg(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4], tbl[i][5] != 0);
      tick(1'b1, 1'b0, 1'b0, 16'h0000);
      tick(1'b0, 1'b0, 1'b0, 16'h0000);
      tick(1'b0, 1'b0, 1'b0, 16'h0000);
      n_vec++; if (cfg_err !== (tbl[i][6] != 0)) begin n_err++; $display("FAIL cfgchk%0d err: got %b want %0d", i, cfg_err, tbl[i][6]); end
      n_vec++; if (frame_h !== 11'(tbl[i][7]) || frame_v !== 11'(tbl[i][8])) begin n_err++; $display("FAIL cfgchk%0d geom: got %0dx%0d want %0dx%0d", i, frame_h, frame_v, tbl[i][7], tbl[i][8]); end
      n_vec++; if (pix_max !== 22'(tbl[i][9])) begin n_err++; $display("FAIL cfgchk%0d pixmax: got %0d want %0d", i, pix_max, tbl[i][9]); end
    end
  endtask

  task automatic test_cfg_err();
    set_cfg(40, 0, 40, 48, 0, 1'b0);
    drive_frame(10);
    n_vec++; if (cap_q.size() != 3072) begin n_err++; $display("FAIL err_pass count: got %0d want 3072", cap_q.size()); end
    n_vec++; if (cap_q.size() > 0 && cap_q[0].d !== pat(0, 0)) begin n_err++; $display("FAIL err_pass first: got %h want %h", cap_q[0].d, pat(0, 0)); end
    n_vec++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL err_flag: got %b want 1", cfg_err); end
    n_vec++; if (frame_h !== 11'd64) begin n_err++; $display("FAIL err_geom: got %0d want 64", frame_h); end
    drive_frame(-1);
    n_vec++; if (cap_q.size() != 1344) begin n_err++; $display("FAIL fix_next count: got %0d want 1344", cap_q.size()); end
    n_vec++; if (cap_q.size() > 0 && cap_q[0].d !== pat(6, 8)) begin n_err++; $display("FAIL fix_next first: got %h want %h", cap_q[0].d, pat(6, 8)); end
    n_vec++; if (cfg_err !== 1'b0 || frame_h !== 11'd48) begin n_err++; $display("FAIL fix_next cfg: got err=%b h=%0d want err=0 h=48", cfg_err, frame_h); end
  endtask

  task automatic test_reset_midframe();
    set_cfg(0, 0, 64, 48, 0, 1'b1);
    cap_q.delete();
    tick(1'b1, 1'b0, 1'b0, 16'h0000);
    tick(1'b0, 1'b0, 1'b0, 16'h0000);
    for (int p = 0; p < SH; p++) tick(1'b0, 1'b1, 1'b1, pat(0, p));
    repeat (3) tick(1'b0, 1'b0, 1'b0, 16'h0000);
    for (int p = 0; p < 20; p++) tick(1'b0, 1'b1, 1'b1, pat(1, p));
    n_vec++; if (out_valid !== 1'b1 || out_data !== pat(1, 19)) begin n_err++; $display("FAIL pre_reset: got v=%b d=%h want v=1 d=%h", out_valid, out_data, pat(1, 19)); end
    rst = 1'b1;
    #1;
    n_vec++; if ({out_valid, out_sof, out_eol} !== 3'b000 || out_data !== 16'h0000) begin n_err++; $display("FAIL async_reset: got v=%b d=%h want v=0 d=0000", out_valid, out_data); end
    tick(1'b0, 1'b1, 1'b1, pat(1, 20));
    rst = 1'b0;
    cap_q.delete();
    for (int p = 21; p < SH; p++) tick(1'b0, 1'b1, 1'b1, pat(1, p));
    repeat (3) tick(1'b0, 1'b0, 1'b0, 16'h0000);
    for (int l = 2; l < 6; l++) begin
      for (int p = 0; p < SH; p++) tick(1'b0, 1'b1, 1'b1, pat(l, p));
      repeat (3) tick(1'b0, 1'b0, 1'b0, 16'h0000);
    end
    n_vec++; if (cap_q.size() != 0) begin n_err++; $display("FAIL post_reset_drop: got %0d pixels want 0", cap_q.size()); end
    tick(1'b1, 1'b1, 1'b1, 16'hBEEF);
    for (int p = 0; p < SH; p++) tick(1'b0, 1'b1, 1'b1, pat(0, p));
    repeat (3) tick(1'b0, 1'b0, 1'b0, 16'h0000);
    n_vec++; if (cap_q.size() != SH) begin n_err++; $display("FAIL sof_pixel count: got %0d want %0d", cap_q.size(), SH); end
    n_vec++; if (cap_q.size() > 0 && cap_q[0] !== {pat(0, 0), 1'b1, 1'b0}) begin n_err++; $display("FAIL sof_pixel first: got %h want %h", cap_q[0], {pat(0, 0), 1'b1, 1'b0}); end
    n_vec++; if (cap_q.size() == SH && cap_q[SH-1] !== {pat(0, SH-1), 1'b0, 1'b1}) begin n_err++; $display("FAIL sof_pixel last: got %h want %h", cap_q[SH-1], {pat(0, SH-1), 1'b0, 1'b1}); end
  endtask

  initial begin
    test_reset();
    test_window("bypass", 8, 6, 48, 28, 1, 1'b1, 0, 0, 1, 64, 48, 3072, 1'b0);
    test_window("win_s0", 8, 6, 48, 28, 0, 1'b0, 8, 6, 1, 48, 28, 1344, 1'b0);
    test_window("win_s1", 8, 6, 48, 28, 1, 1'b0, 8, 6, 2, 24, 14, 336, 1'b0);
    test_window("win_s2", 8, 6, 48, 28, 2, 1'b0, 8, 6, 4, 12, 7, 84, 1'b0);
    test_cfg_checks();
    test_cfg_err();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
